tri_cal_sequencer: RTL and testbench



---
 rtl/tri_cal_sequencer.sv | 139 +++++++++++++
 tb/tb_tri_cal_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tri_cal_sequencer.sv
// tri_cal_sequencer: settle / min-max measure / evaluate sequencer that
// derives the mid-level threshold for the triangle integrator.
// Optional feature: define TRI_CAL_AUTO_RECAL_EN for periodic re-calibration
// every RECAL_PERIOD cycles spent in RUN.
module tri_cal_sequencer #(
  parameter int SETTLE_CYC   = 512,
  parameter int MEAS_CYC     = 1024,
  parameter int MIN_SPAN     = 16,
  parameter int RECAL_PERIOD = 1048576
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       abort,
  input  logic [9:0] sample_in,
  input  logic       sample_vld,
  output logic       busy,
  output logic       done,
  output logic       span_err,
  output logic [9:0] threshold,
  output logic       thr_valid,
  output logic       trk_en,
  output logic [9:0] max_o,
  output logic [9:0] min_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_MEASURE = 3'd2;
  localparam logic [2:0] S_EVAL    = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;

  // One counter serves both the settle window and the sample count.
  localparam int CMAX = (SETTLE_CYC > MEAS_CYC) ? SETTLE_CYC : MEAS_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [9:0]    wmax, wmin;
  logic [10:0]   span, sum;
  logic          auto_start;
  logic          start_acc;

`ifdef TRI_CAL_AUTO_RECAL_EN
  localparam int RW = $clog2(RECAL_PERIOD + 1);
  logic [RW-1:0] run_cnt;

  // RUN dwell counter; held at 0 outside RUN so it restarts on every entry.
  always_ff @(posedge clk) begin
    if (sys_rst || state != S_RUN) run_cnt <= '0;
    else                           run_cnt <= run_cnt + 1'b1;
  end

  assign auto_start = (state == S_RUN) && (run_cnt == RW'(RECAL_PERIOD - 1));
`else
  // Period parameter stays in the port list so both builds share one interface.
  assign auto_start = (RECAL_PERIOD < 0);
`endif

  assign start_acc = (start || auto_start) && (state == S_IDLE || state == S_RUN);
  assign span      = {1'b0, wmax} - {1'b0, wmin};
  assign sum       = {1'b0, wmax} + {1'b0, wmin};
  assign trk_en    = thr_valid;
  assign state_o   = state;

  // Sequencer FSM plus all registered outputs; abort beats every transition.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wmax      <= '0;
      wmin      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      span_err  <= 1'b0;
      threshold <= '0;
      thr_valid <= 1'b0;
      max_o     <= '0;
      min_o     <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        thr_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_RUN: begin
            if (start_acc) begin
              state    <= S_SETTLE;
              busy     <= 1'b1;
              cnt      <= '0;
              span_err <= 1'b0;
              wmax     <= 10'd0;
              wmin     <= 10'd1023;
            end
          end
          S_SETTLE: begin
            if (cnt == CW'(SETTLE_CYC - 1)) begin
              state <= S_MEASURE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_MEASURE: begin
            if (sample_vld) begin
              if (sample_in > wmax) wmax <= sample_in;
              if (sample_in < wmin) wmin <= sample_in;
              if (cnt == CW'(MEAS_CYC - 1)) state <= S_EVAL;
              else                          cnt   <= cnt + 1'b1;
            end
          end
          S_EVAL: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            max_o <= wmax;
            min_o <= wmin;
            if (span >= 11'(MIN_SPAN)) begin
              threshold <= sum[10:1];
              thr_valid <= 1'b1;
              state     <= S_RUN;
            end else begin
              // A failed re-cal keeps the previous good threshold in service.
              span_err <= 1'b1;
              state    <= thr_valid ? S_RUN : S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tri_cal_sequencer.sv
// Directed bench for tri_cal_sequencer (SETTLE_CYC=4, MEAS_CYC=8).
// u_dut uses MIN_SPAN=16; u_hi uses MIN_SPAN=1 for the full-scale corner.
module tb_tri_cal_sequencer;
  logic       clk = 1'b0;
  logic       sys_rst, start, abort, sample_vld;
  logic [9:0] sample_in;

  logic       busy, done, span_err, thr_valid, trk_en;
  logic [9:0] threshold, max_o, min_o;
  logic [2:0] state_o;
  logic       h_busy, h_done, h_span_err, h_thr_valid, h_trk_en;
  logic [9:0] h_threshold, h_max_o, h_min_o;
  logic [2:0] h_state_o;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tri_cal_sequencer #(.SETTLE_CYC(4), .MEAS_CYC(8), .MIN_SPAN(16), .RECAL_PERIOD(20)) u_dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .abort(abort),
    .sample_in(sample_in), .sample_vld(sample_vld),
    .busy(busy), .done(done), .span_err(span_err), .threshold(threshold),
    .thr_valid(thr_valid), .trk_en(trk_en), .max_o(max_o), .min_o(min_o),
    .state_o(state_o));

  tri_cal_sequencer #(.SETTLE_CYC(4), .MEAS_CYC(8), .MIN_SPAN(1), .RECAL_PERIOD(20)) u_hi (
    .clk(clk), .sys_rst(sys_rst), .start(start), .abort(abort),
    .sample_in(sample_in), .sample_vld(sample_vld),
    .busy(h_busy), .done(h_done), .span_err(h_span_err), .threshold(h_threshold),
    .thr_valid(h_thr_valid), .trk_en(h_trk_en), .max_o(h_max_o), .min_o(h_min_o),
    .state_o(h_state_o));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle; returns 1 time unit after the consuming edge.
  task automatic cyc(input logic st, input logic ab, input logic v, input logic [9:0] s);
    start = st; abort = ab; sample_vld = v; sample_in = s;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; sample_vld = 1'b0; sample_in = 10'd0;
  endtask

  task automatic settle4(input logic v, input logic [9:0] s);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, v, s);
  endtask

  logic [9:0] pat1 [8] = '{100, 900, 300, 500, 100, 900, 300, 500};
  logic [9:0] pat2 [8] = '{200, 700, 300, 600, 200, 700, 300, 600};
  logic [9:0] flat [8] = '{507, 517, 512, 510, 515, 508, 511, 513};
  logic [9:0] top2 [8] = '{1023, 1022, 1023, 1022, 1022, 1023, 1022, 1023};

  initial begin
    sys_rst = 1'b1; start = 1'b0; abort = 1'b0; sample_vld = 1'b0; sample_in = '0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_state", state_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_thr", threshold, 0);
    chk("rst_thr_valid", thr_valid, 0);
    chk("rst_min", min_o, 0);
    sys_rst = 1'b0;
    cyc(0, 0, 0, 0);

    // Calibration 1: continuous samples; valid samples during settle are ignored.
    cyc(1, 0, 0, 0);
    chk("c1_settle_state", state_o, 1);
    chk("c1_busy", busy, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 10'd5);
    chk("c1_settle_last", state_o, 1);
    cyc(0, 0, 1, 10'd5);
    chk("c1_measure", state_o, 2);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, pat1[i]);
    chk("c1_eval", state_o, 3);
    chk("c1_eval_done", done, 0);
    chk("c1_eval_busy", busy, 1);
    cyc(0, 0, 0, 0);
    chk("c1_run", state_o, 4);
    chk("c1_done", done, 1);
    chk("c1_max", max_o, 900);
    chk("c1_min", min_o, 100);
    chk("c1_thr", threshold, 500);
    chk("c1_thr_valid", thr_valid, 1);
    chk("c1_trk", trk_en, 1);
    chk("c1_busy_off", busy, 0);
    chk("c1_span_err", span_err, 0);
    cyc(0, 0, 0, 0);
    chk("c1_done_pulse", done, 0);

    // Re-cal with sample_vld on alternate cycles; start mid-measure ignored.
    cyc(1, 0, 0, 0);
    chk("c2_settle", state_o, 1);
    chk("c2_hold_valid", thr_valid, 1);
    settle4(1'b1, 10'd0);
    chk("c2_measure", state_o, 2);
    for (int i = 0; i < 15; i++) begin
      if (i % 2 == 0) cyc(0, 0, 1, pat2[i/2]);
      else            cyc(i == 5, 0, 0, 10'd1023);
      if (i == 5) chk("c2_start_ignored", state_o, 2);
    end
    chk("c2_eval", state_o, 3);
    chk("c2_thr_hold", threshold, 500);
    cyc(0, 0, 0, 0);
    chk("c2_done", done, 1);
    chk("c2_thr", threshold, 450);
    chk("c2_max", max_o, 700);
    chk("c2_min", min_o, 200);

    // Failed re-cal keeps old threshold and stays in RUN.
    cyc(1, 0, 0, 0);
    settle4(1'b0, 10'd0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, flat[i]);
    cyc(0, 0, 0, 0);
    chk("c3_done", done, 1);
    chk("c3_span_err", span_err, 1);
    chk("c3_state", state_o, 4);
    chk("c3_thr", threshold, 450);
    chk("c3_trk", trk_en, 1);
    chk("c3_max", max_o, 517);
    chk("c3_min", min_o, 507);

    // abort together with start during MEASURE.
    cyc(1, 0, 0, 0);
    settle4(1'b0, 10'd0);
    cyc(0, 0, 1, 10'd100);
    cyc(0, 0, 1, 10'd900);
    cyc(1, 1, 1, 10'd300);
    chk("ab_state", state_o, 0);
    chk("ab_busy", busy, 0);
    chk("ab_thr_valid", thr_valid, 0);
    chk("ab_trk", trk_en, 0);
    chk("ab_thr_hold", threshold, 450);
    chk("ab_max_hold", max_o, 517);

    // Flat input from IDLE: rejected, back to IDLE.
    cyc(1, 0, 0, 0);
    settle4(1'b0, 10'd0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, flat[i]);
    cyc(0, 0, 0, 0);
    chk("c5_done", done, 1);
    chk("c5_span_err", span_err, 1);
    chk("c5_state", state_o, 0);
    chk("c5_thr_valid", thr_valid, 0);
    chk("c5_busy", busy, 0);

    // Reset in the middle of SETTLE.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    sys_rst = 1'b1;
    cyc(0, 0, 0, 0);
    chk("mr_state", state_o, 0);
    chk("mr_busy", busy, 0);
    chk("mr_span_err", span_err, 0);
    chk("mr_thr", threshold, 0);
    chk("mr_max", max_o, 0);
    chk("mr_h_thr", h_threshold, 0);
    sys_rst = 1'b0;
    cyc(0, 0, 0, 0);

    // Full-scale samples: 11-bit sum must not wrap.
    cyc(1, 0, 0, 0);
    settle4(1'b0, 10'd0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, top2[i]);
    cyc(0, 0, 0, 0);
    chk("fs_h_thr", h_threshold, 1022);
    chk("fs_h_valid", h_thr_valid, 1);
    chk("fs_h_state", h_state_o, 4);
    chk("fs_h_max", h_max_o, 1023);
    chk("fs_h_min", h_min_o, 1022);
    chk("fs_span_err", span_err, 1);
    chk("fs_state", state_o, 0);

    // Periodic re-cal on u_hi: SETTLE exactly 20 cycles after RUN entry.
    for (int i = 0; i < 19; i++) cyc(0, 0, 0, 0);
    chk("ar_before", h_state_o, 4);
    cyc(0, 0, 0, 0);
`ifdef TRI_CAL_AUTO_RECAL_EN
    chk("ar_fire", h_state_o, 1);
`else
    chk("ar_none", h_state_o, 4);
`endif
    chk("ar_main_idle", state_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
